// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_prog
// Description : Runtime-programmable serial sequence detector. A PAT_W-bit
//               sliding window of qualified serial bits is compared against a
//               loaded pattern under a don't-care mask. A registered one-cycle
//               pulse is raised on each match (overlapping or non-overlapping)
//               and a saturating match counter is kept.
// Ports       : clk          - clock, all logic on posedge
//               rst          - synchronous reset, active low
//               in_valid     - qualifies seq_in
//               seq_in       - serial data bit
//               cfg_load     - latch cfg_pattern/cfg_mask/cfg_overlap, restart
//               cfg_pattern  - pattern, bit PAT_W-1 oldest, bit 0 newest
//               cfg_mask     - per-bit compare enable (0 = don't care)
//               cfg_overlap  - 1 = overlapping detection
//               cnt_clear    - clear match_cnt
//               detect       - registered match pulse
//               match_cnt    - saturating count of detect pulses
//               armed        - high once a configuration has been loaded
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_prog #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             seq_in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clear,
    output logic             detect,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int              FILL_W      = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] c_FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    // The state is not stored separately; it is decoded from armed/fill.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HUNT = 2'd2
    } state_t;

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-1:0]  r_msk;
    logic              r_ovl;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_detect;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_armed;

    state_t            w_state;
    logic [PAT_W-1:0]  w_hist_shift;
    logic [FILL_W-1:0] w_fill_inc;
    logic [PAT_W-1:0]  w_hist_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_match;
    logic [CNT_W-1:0]  w_cnt_base;
    logic [CNT_W-1:0]  w_cnt_n;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pat    <= '0;
            r_msk    <= '0;
            r_ovl    <= 1'b0;
            r_hist   <= '0;
            r_fill   <= '0;
            r_detect <= 1'b0;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_pat   <= cfg_pattern;
                r_msk   <= cfg_mask;
                r_ovl   <= cfg_overlap;
                r_armed <= 1'b1;
            end
            r_hist   <= w_hist_n;
            r_fill   <= w_fill_n;
            r_detect <= w_match;
            r_cnt    <= w_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / match logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = S_IDLE;
        w_hist_shift = {r_hist[PAT_W-2:0], seq_in};
        w_fill_inc   = (r_fill == c_FILL_FULL) ? r_fill : (r_fill + c_FILL_ONE);
        w_hist_n     = r_hist;
        w_fill_n     = r_fill;
        w_match      = 1'b0;

        if (r_armed) begin
            w_state = (r_fill == c_FILL_FULL) ? S_HUNT : S_FILL;
        end

        case (w_state)
            S_FILL, S_HUNT: begin
                if (in_valid && !cfg_load) begin
                    w_hist_n = w_hist_shift;
                    w_fill_n = w_fill_inc;
                    if ((w_fill_inc == c_FILL_FULL) &&
                        (((w_hist_shift ^ r_pat) & r_msk) == '0)) begin
                        w_match = 1'b1;
                        // Non-overlapping: demand PAT_W fresh bits for the
                        // next match while the window keeps shifting.
                        if (!r_ovl) begin
                            w_fill_n = '0;
                        end
                    end
                end
            end
            default: ;
        endcase

        // A load always restarts the window, whatever the current state.
        if (cfg_load) begin
            w_hist_n = '0;
            w_fill_n = '0;
        end
    end

    // Clear takes effect first so a coincident match leaves the count at 1.
    always_comb begin
        w_cnt_base = cnt_clear ? '0 : r_cnt;
        w_cnt_n    = w_cnt_base;
        if (w_match && (w_cnt_base != c_CNT_MAX)) begin
            w_cnt_n = w_cnt_base + c_CNT_ONE;
        end
    end

    assign detect    = r_detect;
    assign match_cnt = r_cnt;
    assign armed     = r_armed;

endmodule
`default_nettype wire

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial sequence detector, the parametrised successor to the fixed-pattern detector. It samples a qualified serial bit stream and compares a PAT_W-bit sliding window against a loaded pattern under a don't-care mask. It pulses `detect` on each match, in overlapping or non-overlapping mode, and keeps a saturating match count. It sits behind the same driver/monitor style interface (`seq_in` in, `detect` out), extended with configuration and counter ports.

## Interface
- PAT_W, 4, window/pattern length in bits; legal range 2..32.
- CNT_W, 16, match counter width; legal range 1..32.

- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset: synchronous, active-low.
- in_valid  input  1  `seq_in` is sampled only when high.
- seq_in  input  1  serial data bit.
- cfg_load  input  1  loads the configuration inputs this cycle.
- cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the oldest bit, bit 0 the newest.
- cfg_mask  input  PAT_W  per-bit compare enable; 0 = don't care.
- cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping.
- cnt_clear  input  1  clears `match_cnt`.
- detect  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  saturating count of `detect` pulses.
- armed  output  1  high once any `cfg_load` has occurred since reset.

## Operation
- Registers:
  - `pat`, `msk`, `ovl`: configuration.
  - `hist[PAT_W-1:0]`: window.
  - `fill`: 0..PAT_W, saturating.
  - `detect`, `match_cnt`, `armed`.
- State machine, encoded by `armed`/`fill`:
  - IDLE (`armed`=0): no shifting, no detection.
  - FILL (`armed`=1, `fill`<PAT_W).
  - HUNT (`armed`=1, `fill`=PAT_W).
  - Any `cfg_load` → FILL with `fill`=0.
- Shift, on `in_valid` && `armed` && !`cfg_load`:
  - hist_n = {hist[PAT_W-2:0], seq_in}
  - fill_n = min(fill+1, PAT_W)
- Match condition, evaluated on the same cycle: `fill_n`==PAT_W && ((hist_n ^ pat) & msk)==0.
  - `msk`=0 matches every valid bit once the window is full.
- On match:
  - `detect` goes high next cycle.
  - If `ovl`=1: `fill` stays PAT_W.
  - If `ovl`=0: `fill` is forced to 0, so the next match needs PAT_W fresh bits. `hist` still shifts.
- `cfg_load`:
  - Latches `cfg_pattern`, `cfg_mask`, `cfg_overlap`.
  - Clears `hist` and `fill`; sets `armed`=1.
  - `in_valid`/`seq_in` that cycle are discarded; no match is evaluated.
  - `match_cnt` is not affected.
- `match_cnt`:
  - +1 per match, saturating at 2^CNT_W-1.
  - `cnt_clear` alone → 0.
  - `cnt_clear` together with a match → 1 (clear, then count).
- `in_valid`=0: everything holds; `detect` is 0 the following cycle.

## Timing
- Reset values (`rst`=0 at posedge): `detect`=0, `match_cnt`=0, `armed`=0, `hist`=0, `fill`=0, `pat`=0, `msk`=0, `ovl`=0.
  - Reset overrides `cfg_load` and `cnt_clear`.
  - Mid-stream reset discards the partial window; no `detect` is produced for bits sampled in the reset cycle.
- Latency: a bit sampled at edge k that completes a match → `detect`=1 and `match_cnt` updated after edge k+1 is visible, i.e. during cycle k+1. Exactly one cycle; no combinational path from inputs to outputs.
- Back-to-back matches: in overlap mode with a periodic pattern (e.g. all-ones), `detect` may stay high on consecutive valid cycles.
- Earliest match after `cfg_load` at edge j: the PAT_W-th valid bit after edge j.
- `armed` rises the cycle after the first `cfg_load` and stays high until reset.

## Test plan
- Overlap: PAT_W=4, `cfg_load` pattern 4'b1011, mask 4'b1111, overlap=1, then stream 1,0,1,1,0,1,1 with `in_valid`=1 → `detect` pulses after the 4th and 7th bits; `match_cnt`=2.
- Non-overlap: same config with overlap=0, same stream → single pulse after the 4th bit; `match_cnt`=1. Appending 0,1,1 → second pulse after the 10th bit.
- Mask and valid gaps: pattern 4'b1001, mask 4'b1001, stream 1,1,1,1 with `in_valid` low for 3 cycles between bits 2 and 3 → one pulse, one cycle after bit 4 only; no pulses during the gaps.
- Saturation and clear: CNT_W=2, mask 0, overlap=1, 8 valid bits → `match_cnt` 1,2,3,3,3. Then `cnt_clear` coincident with a match → `match_cnt`=1.
- Reconfiguration: `cfg_load` after 3 bits of a matching prefix → no detect from the old prefix; a full PAT_W new bits are required; `match_cnt` is unchanged.
- Reset and unarmed: stimulus before any `cfg_load` → `detect` stays 0 and `armed`=0. `rst`=0 mid-window → all outputs 0 on the next cycle; `armed`=0 until the next `cfg_load`.
